// File: rtl/mac_col_mbank.sv
// ---------------------------------------------------------------------------
// mac_col_mbank
//   One column of a systolic MAC chain. Holds NKEY key vectors (banks) of PR
//   signed lanes, captures its own key out of a forwarded load burst, and on
//   execute beats accumulates query.key dot products into a saturating
//   accumulator, emitting one result per reduction with a fifo_wr pulse.
//
// Ports
//   clk      clock
//   reset    synchronous, active-high
//   q_in     query / load vector, lane i = [i*BW +: BW]
//   i_inst   [0] load, [1] execute, [2] last beat of reduction
//   i_bank   key bank for load or execute
//   q_out    q_in delayed one cycle, to next column
//   o_inst   i_inst delayed one cycle, to next column
//   o_bank   i_bank delayed one cycle, to next column
//   out      reduction result, valid while fifo_wr = 1, held otherwise
//   fifo_wr  one-cycle pulse per completed reduction
//   key_vld  bit b set once bank b has been loaded
// ---------------------------------------------------------------------------
module mac_col_mbank #(
  parameter int BW      = 8,
  parameter int PR      = 8,
  parameter int BW_PSUM = 2*BW+6,
  parameter int ACC_BW  = BW_PSUM+4,
  parameter int NKEY    = 2,
  parameter int NUM_COL = 8,
  parameter int COL_ID  = 0,
  parameter int BANK_W  = (NKEY > 1) ? $clog2(NKEY) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PR*BW-1:0]         q_in,
  input  logic [2:0]               i_inst,
  input  logic [BANK_W-1:0]        i_bank,
  output logic [PR*BW-1:0]         q_out,
  output logic [2:0]               o_inst,
  output logic [BANK_W-1:0]        o_bank,
  output logic signed [ACC_BW-1:0] out,
  output logic                     fifo_wr,
  output logic [NKEY-1:0]          key_vld
);

  localparam int CNT_W = $clog2(NUM_COL+1);
  // Beats of a burst that belong to columns further down the chain.
  localparam logic [CNT_W-1:0] LOAD_SKIP = CNT_W'(NUM_COL-1-COL_ID);
  localparam logic [CNT_W-1:0] LOAD_DONE = CNT_W'(NUM_COL-COL_ID);
  localparam logic signed [ACC_BW-1:0] ACC_MAX = {1'b0, {(ACC_BW-1){1'b1}}};
  localparam logic signed [ACC_BW-1:0] ACC_MIN = {1'b1, {(ACC_BW-1){1'b0}}};

  // Stage 1: forwarding registers
  logic [PR*BW-1:0]  query_q;
  logic [2:0]        inst_q;
  logic [BANK_W-1:0] bank_q;

  // Stage 2: key store and accumulator
  logic [PR*BW-1:0]         key_q [NKEY];
  logic [PR*BW-1:0]         key_d [NKEY];
  logic [NKEY-1:0]          kv_q, kv_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_BW-1:0] acc_q, acc_d;
  logic                     first_q, first_d;
  logic signed [ACC_BW-1:0] out_q, out_d;
  logic                     wr_q, wr_d;

  logic [PR*BW-1:0]         key_sel;
  logic signed [BW_PSUM-1:0] psum_w;
  logic signed [ACC_BW-1:0] base_w;
  logic signed [ACC_BW:0]   sum_w;
  logic signed [ACC_BW-1:0] acc_next;

  function automatic logic signed [BW_PSUM-1:0] dot(input logic [PR*BW-1:0] a,
                                                    input logic [PR*BW-1:0] b);
    logic signed [BW_PSUM-1:0] s;
    logic signed [2*BW-1:0]    p;
    s = '0;
    for (int i = 0; i < PR; i++) begin
      p = (2*BW)'($signed(a[i*BW +: BW])) * (2*BW)'($signed(b[i*BW +: BW]));
      s = s + BW_PSUM'(p);
    end
    return s;
  endfunction

  // Bank lookup by compare so a bank code beyond NKEY simply reads zero.
  always_comb begin
    key_sel = '0;
    for (int b = 0; b < NKEY; b++) begin
      if (bank_q == BANK_W'(b)) key_sel = key_q[b];
    end
  end

  assign psum_w = dot(query_q, key_sel);
  assign base_w = first_q ? '0 : acc_q;
  // One guard bit: overflow shows up as a mismatch between the top two bits.
  assign sum_w  = (ACC_BW+1)'(base_w) + (ACC_BW+1)'(psum_w);

  always_comb begin
    if (sum_w[ACC_BW] != sum_w[ACC_BW-1]) acc_next = sum_w[ACC_BW] ? ACC_MIN : ACC_MAX;
    else                                  acc_next = sum_w[ACC_BW-1:0];
  end

  always_comb begin
    key_d   = key_q;
    kv_d    = kv_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    first_d = first_q;
    out_d   = out_q;
    wr_d    = 1'b0;
    if (inst_q[0]) begin
      // Load takes priority over execute; count off the beats meant for
      // downstream columns, capture ours, then ignore the rest of the burst.
      if (cnt_q < LOAD_SKIP) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (cnt_q == LOAD_SKIP) begin
        for (int b = 0; b < NKEY; b++) begin
          if (bank_q == BANK_W'(b)) begin
            key_d[b] = query_q;
            kv_d[b]  = 1'b1;
          end
        end
        cnt_d = LOAD_DONE;
      end
    end else begin
      cnt_d = '0;
      if (inst_q[1]) begin
        acc_d = acc_next;
        if (inst_q[2]) begin
          out_d   = acc_next;
          wr_d    = 1'b1;
          first_d = 1'b1;
        end else begin
          first_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      query_q <= '0;
      inst_q  <= '0;
      bank_q  <= '0;
      key_q   <= '{default: '0};
      kv_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      first_q <= 1'b1;
      out_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      query_q <= q_in;
      inst_q  <= i_inst;
      bank_q  <= i_bank;
      key_q   <= key_d;
      kv_q    <= kv_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      first_q <= first_d;
      out_q   <= out_d;
      wr_q    <= wr_d;
    end
  end

  assign q_out   = query_q;
  assign o_inst  = inst_q;
  assign o_bank  = bank_q;
  assign out     = out_q;
  assign fifo_wr = wr_q;
  assign key_vld = kv_q;

endmodule

// File: tb/tb_mac_col_mbank.sv
// Two columns at COL_ID=2 share one input stream: dut_a with the default
// 26-bit accumulator, dut_b with a 22-bit accumulator for clamping cases.
module tb_mac_col_mbank;

  localparam int BW = 8, PR = 8, NUM_COL = 8, COL = 2;
  localparam int SKIP = NUM_COL - 1 - COL;
  localparam int WA = 26, WB = 22;

  logic              clk = 1'b0;
  logic              reset;
  logic [PR*BW-1:0]  q_in;
  logic [2:0]        i_inst;
  logic [0:0]        i_bank;

  logic [PR*BW-1:0]        qo_a, qo_b;
  logic [2:0]              oi_a, oi_b;
  logic [0:0]              ob_a, ob_b;
  logic signed [WA-1:0]    out_a_w;
  logic signed [WB-1:0]    out_b_w;
  logic                    wr_a, wr_b;
  logic [1:0]              kv_a, kv_b;

  always #5 clk = ~clk;

  mac_col_mbank #(.NUM_COL(NUM_COL), .COL_ID(COL)) dut_a (
    .clk(clk), .reset(reset), .q_in(q_in), .i_inst(i_inst), .i_bank(i_bank),
    .q_out(qo_a), .o_inst(oi_a), .o_bank(ob_a), .out(out_a_w), .fifo_wr(wr_a),
    .key_vld(kv_a));

  mac_col_mbank #(.NUM_COL(NUM_COL), .COL_ID(COL), .ACC_BW(WB)) dut_b (
    .clk(clk), .reset(reset), .q_in(q_in), .i_inst(i_inst), .i_bank(i_bank),
    .q_out(qo_b), .o_inst(oi_b), .o_bank(ob_b), .out(out_b_w), .fifo_wr(wr_b),
    .key_vld(kv_b));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: key table, burst position, two accumulators.
  int          keys [2][PR];
  logic [1:0]  m_kv;
  int          lpos;
  longint      acc_a, acc_b, m_out_a, m_out_b;
  bit          first;
  bit          m_wr;
  logic [2:0]  p_inst;
  logic        p_bank;
  logic [63:0] p_q;
  logic [63:0] exp_q;
  logic [2:0]  exp_inst;
  logic        exp_bank;

  function automatic logic [63:0] splat(input int v);
    logic [63:0] r;
    for (int i = 0; i < PR; i++) r[i*8 +: 8] = v[7:0];
    return r;
  endfunction

  function automatic logic [63:0] rand_vec();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r;
  endfunction

  function automatic int lane(input logic [63:0] v, input int i);
    logic [7:0] b;
    b = v[i*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx, mn;
    mx = (longint'(1) << (w-1)) - 1;
    mn = -(longint'(1) << (w-1));
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < PR; i++) keys[b][i] = 0;
    m_kv = 0; lpos = 0; acc_a = 0; acc_b = 0; m_out_a = 0; m_out_b = 0;
    first = 1; m_wr = 0; p_inst = 0; p_bank = 0; p_q = 0;
    exp_q = 0; exp_inst = 0; exp_bank = 0;
  endtask

  // Apply one beat, clock it in, advance the model, settle 1 time unit.
  task automatic step(input bit rst, input logic [2:0] inst, input logic bank,
                      input logic [63:0] q);
    longint ps;
    reset = rst; i_inst = inst; i_bank = bank; q_in = q;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_wr = 0;
      if (p_inst[0]) begin
        if (lpos == SKIP) begin
          for (int i = 0; i < PR; i++) keys[p_bank][i] = lane(p_q, i);
          m_kv[p_bank] = 1'b1;
        end
        lpos++;
      end else begin
        lpos = 0;
        if (p_inst[1]) begin
          ps = 0;
          for (int i = 0; i < PR; i++) ps += longint'(lane(p_q, i)) * keys[p_bank][i];
          acc_a = sat((first ? 0 : acc_a) + ps, WA);
          acc_b = sat((first ? 0 : acc_b) + ps, WB);
          if (p_inst[2]) begin
            m_out_a = acc_a; m_out_b = acc_b; m_wr = 1; first = 1;
          end else begin
            first = 0;
          end
        end
      end
      p_inst = inst; p_bank = bank; p_q = q;
      exp_q = q; exp_inst = inst; exp_bank = bank;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 3'b000, 1'b0, 64'd0);
  endtask

  task automatic load_burst(input logic bank, input int mine, input logic [2:0] inst);
    for (int j = 0; j < NUM_COL; j++)
      step(0, inst, bank, (j == SKIP) ? splat(mine) : rand_vec());
  endtask

  task automatic test_reset();
    step(1, 3'b000, 1'b0, 64'd0);
    step(1, 3'b111, 1'b1, rand_vec());
    n_tests++;
    if (out_a_w !== '0 || wr_a !== 1'b0 || kv_a !== 2'b00 || qo_a !== '0 || oi_a !== 3'b000 || ob_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: out=%0d wr=%b kv=%b q_out=%h o_inst=%b o_bank=%b, want all 0",
               out_a_w, wr_a, kv_a, qo_a, oi_a, ob_a);
    end
    n_tests++;
    if (out_b_w !== '0 || wr_b !== 1'b0 || kv_b !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_b: out=%0d wr=%b kv=%b, want 0", out_b_w, wr_b, kv_b);
    end
    idle(1);
  endtask

  task automatic test_load();
    for (int j = 0; j < NUM_COL; j++) begin
      step(0, 3'b001, 1'b0, splat(j+1));
      n_tests++;
      if (qo_a !== splat(j+1) || oi_a !== 3'b001 || ob_a !== 1'b0) begin
        n_fail++;
        $display("FAIL load_fwd beat %0d: q_out=%h o_inst=%b, want %h 001", j, qo_a, oi_a, splat(j+1));
      end
    end
    idle(2);
    n_tests++;
    if (kv_a !== 2'b01 || kv_b !== 2'b01) begin
      n_fail++;
      $display("FAIL load_kv: key_vld=%b/%b, want 01", kv_a, kv_b);
    end
  endtask

  task automatic test_single();
    step(0, 3'b110, 1'b0, splat(1));
    n_tests++;
    if (wr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_early: fifo_wr=%b one edge after issue, want 0", wr_a);
    end
    idle(1);
    n_tests++;
    if (wr_a !== 1'b1 || out_a_w !== 26'sd48) begin
      n_fail++;
      $display("FAIL single: fifo_wr=%b out=%0d, want 1 48", wr_a, out_a_w);
    end
    idle(1);
    n_tests++;
    if (wr_a !== 1'b0 || out_a_w !== 26'sd48) begin
      n_fail++;
      $display("FAIL single_hold: fifo_wr=%b out=%0d, want 0 48", wr_a, out_a_w);
    end
  endtask

  task automatic test_accum();
    int pulses;
    longint last;
    pulses = 0; last = 0;
    for (int b = 1; b <= 3; b++) begin
      step(0, (b == 3) ? 3'b110 : 3'b010, 1'b0, splat(b));
      if (wr_a) begin pulses++; last = longint'(out_a_w); end
      for (int k = 0; k < 2; k++) begin
        idle(1);
        if (wr_a) begin pulses++; last = longint'(out_a_w); end
      end
    end
    n_tests++;
    if (pulses != 1 || last != 288) begin
      n_fail++;
      $display("FAIL accum: pulses=%0d out=%0d, want 1 288", pulses, last);
    end
    step(0, 3'b110, 1'b0, splat(1));
    idle(1);
    n_tests++;
    if (wr_a !== 1'b1 || out_a_w !== 26'sd48) begin
      n_fail++;
      $display("FAIL accum_restart: fifo_wr=%b out=%0d, want 1 48", wr_a, out_a_w);
    end
  endtask

  task automatic test_banks();
    longint want [4];
    want = '{48, -16, 48, -16};
    load_burst(1'b1, -2, 3'b001);
    idle(1);
    n_tests++;
    if (kv_a !== 2'b11) begin
      n_fail++;
      $display("FAIL banks_kv: key_vld=%b, want 11", kv_a);
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) step(0, 3'b110, k[0], splat(1));
      else       idle(1);
      if (k > 0) begin
        n_tests++;
        if (wr_a !== 1'b1 || longint'(out_a_w) != want[k-1]) begin
          n_fail++;
          $display("FAIL banks[%0d]: fifo_wr=%b out=%0d, want 1 %0d", k-1, wr_a, out_a_w, want[k-1]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    load_burst(1'b0, -128, 3'b001);
    for (int k = 0; k < 16; k++) step(0, (k == 15) ? 3'b110 : 3'b010, 1'b0, splat(-128));
    idle(1);
    n_tests++;
    if (wr_b !== 1'b1 || out_b_w !== 22'sd2097151) begin
      n_fail++;
      $display("FAIL sat_pos: fifo_wr=%b out=%0d, want 1 2097151", wr_b, out_b_w);
    end
    n_tests++;
    if (out_a_w !== 26'sd2097152) begin
      n_fail++;
      $display("FAIL sat_pos_wide: out=%0d, want 2097152", out_a_w);
    end
    for (int k = 0; k < 20; k++) step(0, (k == 19) ? 3'b110 : 3'b010, 1'b0, splat(127));
    idle(1);
    n_tests++;
    if (wr_b !== 1'b1 || out_b_w !== -22'sd2097152) begin
      n_fail++;
      $display("FAIL sat_neg: fifo_wr=%b out=%0d, want 1 -2097152", wr_b, out_b_w);
    end
    n_tests++;
    if (out_a_w !== -26'sd2600960) begin
      n_fail++;
      $display("FAIL sat_neg_wide: out=%0d, want -2600960", out_a_w);
    end
  endtask

  task automatic test_corners();
    int pulses;
    // Load together with execute+last: load wins, key still captured.
    step(1, 3'b000, 1'b0, 64'd0);
    idle(1);
    pulses = 0;
    for (int j = 0; j < NUM_COL; j++) begin
      step(0, 3'b111, 1'b1, (j == SKIP) ? splat(5) : rand_vec());
      if (wr_a) pulses++;
    end
    idle(1);
    if (wr_a) pulses++;
    n_tests++;
    if (pulses != 0 || kv_a !== 2'b10) begin
      n_fail++;
      $display("FAIL load_exec: pulses=%0d key_vld=%b, want 0 10", pulses, kv_a);
    end
    step(0, 3'b110, 1'b1, splat(1));
    idle(1);
    n_tests++;
    if (wr_a !== 1'b1 || out_a_w !== 26'sd40) begin
      n_fail++;
      $display("FAIL load_exec_key: fifo_wr=%b out=%0d, want 1 40", wr_a, out_a_w);
    end
    // Reset between beats 2 and 3 of a reduction.
    load_burst(1'b0, 6, 3'b001);
    step(0, 3'b010, 1'b0, splat(1)); idle(2);
    step(0, 3'b010, 1'b0, splat(2)); idle(2);
    step(1, 3'b000, 1'b0, 64'd0);
    idle(1);
    n_tests++;
    if (kv_a !== 2'b00 || wr_a !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: key_vld=%b fifo_wr=%b, want 00 0", kv_a, wr_a);
    end
    step(0, 3'b110, 1'b0, splat(3));
    idle(1);
    n_tests++;
    if (wr_a !== 1'b1 || out_a_w !== 26'sd0) begin
      n_fail++;
      $display("FAIL mid_reset_exec: fifo_wr=%b out=%0d, want 1 0", wr_a, out_a_w);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        step(1, 3'($urandom()), 1'($urandom()), rand_vec());
      end else if (r < 10) begin
        load_burst(1'($urandom()), int'($urandom_range(0, 255)) - 128, 3'b001);
      end else begin
        step(0, (r < 15) ? 3'($urandom()) : {1'($urandom()), 1'b1, 1'b0},
             1'($urandom()), rand_vec());
      end
      n_tests++;
      if (wr_a !== m_wr || wr_b !== m_wr || longint'(out_a_w) != m_out_a ||
          longint'(out_b_w) != m_out_b) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: wr=%b/%b out=%0d/%0d, want %b %0d/%0d",
                 n, wr_a, wr_b, out_a_w, out_b_w, m_wr, m_out_a, m_out_b);
      end
      n_tests++;
      if (kv_a !== m_kv || qo_a !== exp_q || oi_a !== exp_inst || ob_a !== exp_bank) begin
        n_fail++;
        $display("FAIL rand_fwd[%0d]: kv=%b q=%h i=%b b=%b, want %b %h %b %b",
                 n, kv_a, qo_a, oi_a, ob_a, m_kv, exp_q, exp_inst, exp_bank);
      end
    end
  endtask

  initial begin
    reset = 1'b1; q_in = '0; i_inst = '0; i_bank = '0;
    model_clear();
    test_reset();
    test_load();
    test_single();
    test_accum();
    test_banks();
    test_saturation();
    test_corners();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
